// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios input PIO: register addresses, edge-type
// encodings and the debounce counter width helper.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // A single-cycle debounce still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer, hold-time debounce counter and the
// accepted (stable) value, plus combinational rise/fall on the pending update.
module pio_debounce_bit
  import nios_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    accept   = (sync_q != stable_q) && (cnt_q == CNT_MAX);
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= in_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Edges flag the update about to happen so capture lands on the same edge.
  assign stable_o = stable_q;
  assign rise_o   = accept & ~stable_q;
  assign fall_o   = accept &  stable_q;

endmodule

// File: rtl/nios_button_pio.sv
// Avalon-MM input PIO for push-buttons/switches: per-bit debounce, sticky
// edge capture with write-1-to-clear, and a masked level interrupt.
module nios_button_pio
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Avalon-MM handshake: no backpressure. A write is taken on any clk edge with
  // chipselect=1 and write_n=0; readdata is a combinational mux of address.
  logic [WIDTH-1:0] stable, rise, fall, edge_set, wr_clr;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = &{1'b0, writedata};

  always_comb begin
    if (EDGE_TYPE == EDGE_RISE)      edge_set = rise;
    else if (EDGE_TYPE == EDGE_FALL) edge_set = fall;
    else                             edge_set = rise | fall;

    wr_clr     = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    irq_mask_d = (wr_en && address == ADDR_IRQ_MASK) ? writedata[WIDTH-1:0] : irq_mask_q;
    // A new edge beats a simultaneous clear of the same bit.
    edge_cap_d = (edge_cap_q & ~wr_clr) | edge_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios_button_pio.sv
// Directed bench for nios_button_pio: two instances share the bus and inputs,
// one capturing rising edges only and one capturing both edges.
module tb_nios_button_pio;
  import nios_pio_pkg::*;

  localparam int W  = 4;
  localparam int DB = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_port    = '0;
  logic [31:0]   readdata, readdata_any;
  logic          irq, irq_any;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  nios_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(EDGE_RISE)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  nios_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(EDGE_ANY)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_any), .irq(irq_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic expect_rd(input string tag, input bit any_dut, input logic [1:0] a,
                           input logic [31:0] e);
    address = a;
    exp_q.push_back(e);
    #1;
    check(tag, any_dut ? readdata_any : readdata, exp_q.pop_front());
  endtask

  initial begin
    // reset state, before any clk edge
    expect_rd("rst_data", 0, ADDR_DATA, 32'h0);
    expect_rd("rst_mask", 0, ADDR_IRQ_MASK, 32'h0);
    expect_rd("rst_rsvd", 0, ADDR_RSVD, 32'h0);
    expect_rd("rst_cap", 0, ADDR_EDGE_CAP, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

    // accept: 0101 becomes stable exactly DB+1 edges after first sample
    in_port = 4'b0101;
    tick(5);
    expect_rd("acc_early", 0, ADDR_DATA, 32'h0);
    tick(1);
    expect_rd("acc_data", 0, ADDR_DATA, 32'h5);
    expect_rd("acc_cap", 0, ADDR_EDGE_CAP, 32'h5);
    expect_rd("acc_cap_any", 1, ADDR_EDGE_CAP, 32'h5);
    check("acc_irq", {31'b0, irq}, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'hFFFF_FFF1);
    check("mask_irq", {31'b0, irq}, 32'h1);
    expect_rd("mask_rd", 0, ADDR_IRQ_MASK, 32'h1);
    bus_write(ADDR_DATA, 32'hF);
    bus_write(ADDR_RSVD, 32'hF);
    expect_rd("data_ro", 0, ADDR_DATA, 32'h5);
    expect_rd("rsvd_rd", 0, ADDR_RSVD, 32'h0);

    // glitch: 3-cycle pulse on bit 1 is rejected
    in_port = 4'b0111;
    tick(3);
    in_port = 4'b0101;
    tick(10);
    expect_rd("glitch_data", 0, ADDR_DATA, 32'h5);
    expect_rd("glitch_cap", 0, ADDR_EDGE_CAP, 32'h5);
    check("glitch_irq", {31'b0, irq}, 32'h1);

    // 6-cycle pulse on bit 1 is accepted, its fall is not captured (rise mode)
    in_port = 4'b0111;
    tick(6);
    expect_rd("long_data_hi", 0, ADDR_DATA, 32'h7);
    in_port = 4'b0101;
    tick(12);
    expect_rd("long_data_lo", 0, ADDR_DATA, 32'h5);
    expect_rd("long_cap", 0, ADDR_EDGE_CAP, 32'h7);
    expect_rd("long_cap_any", 1, ADDR_EDGE_CAP, 32'h7);

    // clear: w1c on capture
    bus_write(ADDR_EDGE_CAP, 32'h2);
    expect_rd("clr1_cap", 0, ADDR_EDGE_CAP, 32'h5);
    check("clr1_irq", {31'b0, irq}, 32'h1);
    bus_write(ADDR_EDGE_CAP, 32'hFFFF_FFF1);
    expect_rd("clr2_cap", 0, ADDR_EDGE_CAP, 32'h4);
    check("clr2_irq", {31'b0, irq}, 32'h0);

    // clear of bit 0 on the same edge that bit 0 rises: set wins
    in_port = 4'b0100;
    tick(10);
    expect_rd("fall0_data", 0, ADDR_DATA, 32'h4);
    expect_rd("fall0_cap", 0, ADDR_EDGE_CAP, 32'h4);
    in_port = 4'b0101;
    tick(5);
    expect_rd("coll_pre", 0, ADDR_DATA, 32'h4);
    bus_write(ADDR_EDGE_CAP, 32'h1);
    expect_rd("coll_data", 0, ADDR_DATA, 32'h5);
    expect_rd("coll_cap", 0, ADDR_EDGE_CAP, 32'h5);
    check("coll_irq", {31'b0, irq}, 32'h1);

    // edge type: bit 2 falling is ignored in rise mode, captured in any mode
    bus_write(ADDR_EDGE_CAP, 32'hF);
    expect_rd("et_clr", 0, ADDR_EDGE_CAP, 32'h0);
    expect_rd("et_clr_any", 1, ADDR_EDGE_CAP, 32'h0);
    in_port = 4'b0001;
    tick(10);
    expect_rd("et_data", 0, ADDR_DATA, 32'h1);
    expect_rd("et_fall_rise", 0, ADDR_EDGE_CAP, 32'h0);
    expect_rd("et_fall_any", 1, ADDR_EDGE_CAP, 32'h4);
    check("et_irq_any", {31'b0, irq_any}, 32'h0);
    bus_write(ADDR_EDGE_CAP, 32'hF);
    in_port = 4'b0101;
    tick(10);
    expect_rd("et_rise_rise", 0, ADDR_EDGE_CAP, 32'h4);
    expect_rd("et_rise_any", 1, ADDR_EDGE_CAP, 32'h4);

    // asynchronous reset mid-cycle clears everything without a clk edge
    #3;
    reset_n = 1'b0;
    expect_rd("arst_data", 0, ADDR_DATA, 32'h0);
    expect_rd("arst_mask", 0, ADDR_IRQ_MASK, 32'h0);
    expect_rd("arst_rsvd", 0, ADDR_RSVD, 32'h0);
    expect_rd("arst_cap", 0, ADDR_EDGE_CAP, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    in_port = 4'b0000;
    tick(1);
    reset_n = 1'b1;
    tick(8);
    expect_rd("idle_data", 0, ADDR_DATA, 32'h0);

    // reset mid-debounce, input held high through reset
    in_port = 4'b0001;
    tick(2);
    tick(2);
    #3;
    reset_n = 1'b0;
    expect_rd("mdb_data", 0, ADDR_DATA, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    expect_rd("mdb_early", 0, ADDR_DATA, 32'h0);
    tick(1);
    expect_rd("mdb_data_acc", 0, ADDR_DATA, 32'h1);
    expect_rd("mdb_cap", 0, ADDR_EDGE_CAP, 32'h1);
    check("mdb_irq", {31'b0, irq}, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'h1);
    check("mdb_irq_mask", {31'b0, irq}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
